// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds symbol alignment on DVI control tokens and
// decodes aligned 10-bit symbols into pixel data plus DE/C0/C1.
module tmds_channel_decoder #(
  parameter int unsigned SEARCH_WIN = 1024,
  parameter int unsigned LOCK_COUNT = 32
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic [9:0] raw_in,
  output logic [7:0] dout,
  output logic       de,
  output logic       c0,
  output logic       c1,
  output logic       locked,
  output logic [3:0] offset,
  output logic [7:0] relock_cnt
);

  localparam int unsigned DWELL_W = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
  localparam int unsigned TOK_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(SEARCH_WIN - 1);
  localparam logic [TOK_W-1:0]   TOK_LAST  = TOK_W'(LOCK_COUNT - 1);
  localparam logic [TOK_W-1:0]   TOK_FULL  = TOK_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         offset_q, offset_d, offset_adv;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
  logic [7:0]         relock_q, relock_d;
  logic [9:0]         r_cur_q, r_cur_d, r_prev_q, r_prev_d;
  logic [7:0]         dout_q, dout_d;
  logic               de_q, de_d, c0_q, c0_d, c1_q, c1_d, locked_q, locked_d;

  logic [19:0] w20;
  logic [9:0]  a;
  logic        is_tok;
  logic [1:0]  tok_c;
  logic [7:0]  q, d;

  // Stage 1: two-word window so any of the ten bit phases can be selected
  always_comb begin
    r_cur_d  = raw_in;
    r_prev_d = r_cur_q;
    w20      = {r_cur_q, r_prev_q};
    a        = 10'(w20 >> offset_q);
    offset_adv = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  end

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (a)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // TMDS data decode: undo optional inversion, then XOR/XNOR chain
  always_comb begin
    q    = a[9] ? ~a[7:0] : a[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = a[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    dwell_d   = dwell_q;
    tok_cnt_d = tok_cnt_q;
    relock_d  = relock_q;
    case (state_q)
      ST_SEARCH: begin
        if (is_tok) begin
          state_d   = ST_VERIFY;
          tok_cnt_d = TOK_W'(1);
          dwell_d   = '0;
        end else if (dwell_q == DWELL_MAX) begin
          offset_d = offset_adv;
          dwell_d  = '0;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      ST_VERIFY: begin
        if (is_tok) begin
          if (tok_cnt_q >= TOK_LAST) begin
            state_d   = ST_LOCKED;
            tok_cnt_d = TOK_FULL;
            dwell_d   = '0;
          end else begin
            tok_cnt_d = tok_cnt_q + TOK_W'(1);
          end
        end else begin
          state_d   = ST_SEARCH;
          offset_d  = offset_adv;
          tok_cnt_d = '0;
          dwell_d   = '0;
        end
      end
      ST_LOCKED: begin
        // A token on the last dwell cycle still holds lock
        if (is_tok) begin
          dwell_d = '0;
        end else if (dwell_q == DWELL_MAX) begin
          state_d   = ST_SEARCH;
          offset_d  = offset_adv;
          dwell_d   = '0;
          tok_cnt_d = '0;
          relock_d  = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: begin
        state_d   = ST_SEARCH;
        offset_d  = '0;
        dwell_d   = '0;
        tok_cnt_d = '0;
      end
    endcase
  end

  // Stage 2: outputs are only live for words seen while lock is held
  always_comb begin
    dout_d   = '0;
    de_d     = 1'b0;
    c0_d     = 1'b0;
    c1_d     = 1'b0;
    locked_d = (state_d == ST_LOCKED);
    if (state_q == ST_LOCKED && state_d == ST_LOCKED) begin
      if (is_tok) begin
        c0_d = tok_c[0];
        c1_d = tok_c[1];
      end else begin
        de_d   = 1'b1;
        c0_d   = c0_q;
        c1_d   = c1_q;
        dout_d = d;
      end
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      state_q   <= ST_SEARCH;
      offset_q  <= '0;
      dwell_q   <= '0;
      tok_cnt_q <= '0;
      relock_q  <= '0;
      r_cur_q   <= '0;
      r_prev_q  <= '0;
      dout_q    <= '0;
      de_q      <= 1'b0;
      c0_q      <= 1'b0;
      c1_q      <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      dwell_q   <= dwell_d;
      tok_cnt_q <= tok_cnt_d;
      relock_q  <= relock_d;
      r_cur_q   <= r_cur_d;
      r_prev_q  <= r_prev_d;
      dout_q    <= dout_d;
      de_q      <= de_d;
      c0_q      <= c0_d;
      c1_q      <= c1_d;
      locked_q  <= locked_d;
    end
  end

  assign dout       = dout_q;
  assign de         = de_q;
  assign c0         = c0_q;
  assign c1         = c1_q;
  assign locked     = locked_q;
  assign offset     = offset_q;
  assign relock_cnt = relock_q;

endmodule
